// File: rtl/lfsr_rand_gen_pkg.sv
// Shared constants and types for the whack-a-mole random source.
// Holds feedback masks and non-zero seeds for the widths in use, plus the
// two-state sampling FSM encoding shared by the top level and any consumers.
package lfsr_rand_gen_pkg;

  // Maximal-length feedback masks and safe seeds for common widths.
  localparam logic [3:0]  TAPS_W4   = 4'hC;
  localparam logic [3:0]  SEED_W4   = 4'h1;
  localparam logic [12:0] TAPS_W13  = 13'h100D;
  localparam logic [12:0] SEED_W13  = 13'h000F;

  // Number of mole holes on the board; default accepted sample range.
  localparam int NUM_HOLES = 9;

  // Width of the saturating rejection statistic.
  localparam int REJ_W = 8;

  // FILL shifts towards the next candidate, HOLD presents an accepted sample.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/lfsr_rand_gen_core.sv
// Fibonacci LFSR shift register with seed mux and lock-up guard.
// The next-state value is exposed (low OUT_W bits) so the sampler can judge
// the post-shift candidate in the same cycle the shift happens.
module lfsr_rand_gen_core
  import lfsr_rand_gen_pkg::*;
#(
  parameter int               WIDTH        = 13,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_W13,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = SEED_W13,
  parameter int               OUT_W        = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [OUT_W-1:0] sample_o
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic             feedback;
  logic [WIDTH-1:0] shifted;

  assign feedback = ^(lfsr_q & TAPS);
  assign shifted  = {lfsr_q[WIDTH-2:0], feedback};

  // Seed load wins, then recovery from the all-zero lock-up state, then a shift.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? DEFAULT_SEED : seed_i;
    end else if (lfsr_q == '0) begin
      lfsr_d = DEFAULT_SEED;
    end else if (shift_en_i) begin
      lfsr_d = shifted;
    end
  end

  // Shift register state; reset returns to the non-zero default seed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= DEFAULT_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign sample_o = lfsr_d[OUT_W-1:0];

endmodule

// File: rtl/lfsr_rand_gen.sv
// Range-limited random index source for the whack-a-mole game.
// An LFSR core shifts whenever play is high; every SHIFTS shifts the low
// OUT_W bits form a candidate that is either offered over valid/ready or
// rejected (and counted) when it falls outside 0..RANGE-1.
module lfsr_rand_gen
  import lfsr_rand_gen_pkg::*;
#(
  parameter int               WIDTH        = 13,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_W13,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = SEED_W13,
  parameter int               OUT_W        = 4,
  parameter int               SHIFTS       = 13,
  parameter int               RANGE        = NUM_HOLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             play,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [OUT_W-1:0] rnd,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [7:0]       reject_cnt
);

  // Counter wide enough to reach SHIFTS-1; a single bit when SHIFTS is 1.
  localparam int                 CNT_W   = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
  localparam logic [CNT_W-1:0]   LAST    = CNT_W'(SHIFTS - 1);
  // One extra bit so RANGE = 2**OUT_W is representable and accepts everything.
  localparam logic [OUT_W:0]     RANGE_L = (OUT_W + 1)'(RANGE);
  localparam logic [REJ_W-1:0]   REJ_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] rnd_q, rnd_d;
  logic             valid_q, valid_d;
  logic [REJ_W-1:0] rej_q, rej_d;

  logic [OUT_W-1:0] candidate;
  logic             candidateOk;
  logic             handshake;

  lfsr_rand_gen_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED),
    .OUT_W        (OUT_W)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .shift_en_i (play),
    .load_i     (seed_load),
    .seed_i     (seed_in),
    .sample_o   (candidate)
  );

  assign candidateOk = ({1'b0, candidate} < RANGE_L);
  assign handshake   = valid_q & rnd_ready;

  // Sampling FSM: counts shifts in FILL, judges candidates, holds in HOLD.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rnd_d   = rnd_q;
    valid_d = valid_q;
    rej_d   = rej_q;

    if (seed_load) begin
      state_d = FILL;
      count_d = '0;
      valid_d = 1'b0;
      rej_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (play) begin
            if (count_q == LAST) begin
              count_d = '0;
              if (candidateOk) begin
                rnd_d   = candidate;
                valid_d = 1'b1;
                state_d = HOLD;
              end else if (rej_q != REJ_MAX) begin
                rej_d = rej_q + 1'b1;
              end
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          count_d = '0;
          if (handshake) begin
            valid_d = 1'b0;
            state_d = FILL;
          end
        end
        default: begin
          state_d = FILL;
          count_d = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // FSM, counter, sample and statistic registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      rej_q   <= rej_d;
    end
  end

  assign rnd        = rnd_q;
  assign rnd_valid  = valid_q;
  assign reject_cnt = rej_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Testbench for lfsr_rand_gen: directed steps plus randomized traffic,
// checked against an arithmetic reference model of the random source.
module tb_lfsr_rand_gen;
  import lfsr_rand_gen_pkg::*;

  localparam int M_W      = 13;
  localparam int M_TAPS   = 'h100D;
  localparam int M_SEED   = 'h000F;
  localparam int M_SHIFTS = 13;
  localparam int M_RANGE  = 9;
  localparam int M_OUTMOD = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance (defaults)
  logic        reset, play, seedLoad, rndReady;
  logic [12:0] seedIn;
  logic [3:0]  rnd;
  logic        rndValid;
  logic [7:0]  rejectCnt;

  // 4-bit instance
  logic        reset4;
  logic [3:0]  rnd4;
  logic        valid4;
  logic [7:0]  rej4;

  // RANGE=1 instance
  logic        resetR;
  logic [3:0]  rndR;
  logic        validR;
  logic [7:0]  rejR;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  int mLfsr, mCount, mRnd, mValid, mRej;

  lfsr_rand_gen dut (
    .clock(clock), .reset(reset), .play(play), .seed_load(seedLoad),
    .seed_in(seedIn), .rnd(rnd), .rnd_valid(rndValid), .rnd_ready(rndReady),
    .reject_cnt(rejectCnt)
  );

  lfsr_rand_gen #(.WIDTH(4), .TAPS(4'hC), .DEFAULT_SEED(4'h1), .OUT_W(4),
                  .SHIFTS(1), .RANGE(16)) dut4 (
    .clock(clock), .reset(reset4), .play(1'b1), .seed_load(1'b0),
    .seed_in(4'h0), .rnd(rnd4), .rnd_valid(valid4), .rnd_ready(1'b1),
    .reject_cnt(rej4)
  );

  lfsr_rand_gen #(.SHIFTS(1), .RANGE(1)) dutR (
    .clock(clock), .reset(resetR), .play(1'b1), .seed_load(1'b0),
    .seed_in(13'h0), .rnd(rndR), .rnd_valid(validR), .rnd_ready(1'b1),
    .reject_cnt(rejR)
  );

  // Next LFSR value: double the state, add parity of tapped bits, wrap to width.
  function automatic int lfsrNext(input int s, input int w, input int taps);
    int fb;
    fb = $countones(s & taps) % 2;
    return (s * 2 + fb) % (1 << w);
  endfunction

  task automatic modelReset();
    mLfsr = M_SEED; mCount = 0; mRnd = 0; mValid = 0; mRej = 0;
  endtask

  // One clock of the reference: shifts-since-candidate counting, range test.
  task automatic modelStep(input logic p, input logic ld, input int sd, input logic rdy);
    if (ld) begin
      mLfsr  = (sd == 0) ? M_SEED : sd;
      mCount = 0; mValid = 0; mRej = 0;
    end else begin
      if (mLfsr == 0) mLfsr = M_SEED;
      else if (p)     mLfsr = lfsrNext(mLfsr, M_W, M_TAPS);
      if (mValid == 1) begin
        if (rdy) mValid = 0;
      end else if (p) begin
        mCount++;
        if (mCount == M_SHIFTS) begin
          mCount = 0;
          if ((mLfsr % M_OUTMOD) < M_RANGE) begin
            mRnd = mLfsr % M_OUTMOD;
            mValid = 1;
          end else if (mRej < 255) begin
            mRej++;
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkMain(input string tag);
    checkOutput({tag, " rnd"},       32'(rnd),       32'(mRnd));
    checkOutput({tag, " rnd_valid"}, 32'(rndValid),  32'(mValid));
    checkOutput({tag, " reject_cnt"},32'(rejectCnt), 32'(mRej));
    checkOutput({tag, " lfsr"},      32'(dut.u_core.lfsr_q), 32'(mLfsr));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input logic p, input logic ld, input logic [12:0] sd,
                               input logic rdy, input string tag);
    play = p; seedLoad = ld; seedIn = sd; rndReady = rdy;
    modelStep(p, ld, int'(sd), rdy);
    @(posedge clock);
    #1;
    checkMain(tag);
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!rndValid && n < 300) begin
      applyStimulus(1'b1, 1'b0, 13'h0, 1'b0, tag);
      n++;
    end
    checkOutput({tag, " valid seen"}, 32'(rndValid), 32'd1);
    checkOutput({tag, " rnd below 9"}, 32'(rnd < 4'd9), 32'd1);
  endtask

  initial begin
    logic [3:0]  heldRnd;
    logic [7:0]  heldRej;
    logic [12:0] heldLfsr;
    int gap, period, e;

    reset = 1'b1; reset4 = 1'b1; resetR = 1'b1;
    play = 1'b0; seedLoad = 1'b0; seedIn = '0; rndReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    modelReset();
    checkMain("reset");

    // First shifts from the default seed
    applyStimulus(1'b1, 1'b0, 13'h0, 1'b0, "shift1");
    checkOutput("lfsr after 1", 32'(dut.u_core.lfsr_q), 32'h001F);
    applyStimulus(1'b1, 1'b0, 13'h0, 1'b0, "shift2");
    checkOutput("lfsr after 2", 32'(dut.u_core.lfsr_q), 32'h003F);
    waitValid("first");

    // Back-pressure: sample and statistic stay put
    heldRnd = rnd; heldRej = rejectCnt;
    repeat (50) applyStimulus(1'b1, 1'b0, 13'h0, 1'b0, "stall");
    checkOutput("stall rnd const", 32'(rnd), 32'(heldRnd));
    checkOutput("stall rej const", 32'(rejectCnt), 32'(heldRej));

    // One-cycle accept, then measure the gap to the next sample
    applyStimulus(1'b1, 1'b0, 13'h0, 1'b1, "accept");
    checkOutput("accept drops valid", 32'(rndValid), 32'd0);
    gap = 0;
    while (!rndValid && gap < 300) begin
      applyStimulus(1'b1, 1'b0, 13'h0, 1'b0, "gap");
      gap++;
    end
    checkOutput("gap at least 13", 32'(gap >= 13), 32'd1);
    checkOutput("gap valid seen", 32'(rndValid), 32'd1);

    // Zero seed load falls back to the default seed
    applyStimulus(1'b1, 1'b1, 13'h0, 1'b1, "seed0");
    checkOutput("seed0 lfsr", 32'(dut.u_core.lfsr_q), 32'h000F);
    checkOutput("seed0 valid", 32'(rndValid), 32'd0);
    checkOutput("seed0 rej", 32'(rejectCnt), 32'd0);

    // play low in FILL freezes the register; timing is checked by the model
    repeat (5) applyStimulus(1'b1, 1'b0, 13'h0, 1'b0, "pre-freeze");
    heldLfsr = dut.u_core.lfsr_q;
    repeat (20) applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, "freeze");
    checkOutput("freeze lfsr", 32'(dut.u_core.lfsr_q), 32'(heldLfsr));
    waitValid("after freeze");

    // Handshake completes with play low
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b1, "hold play0");
    checkOutput("hold play0 valid", 32'(rndValid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic p, ld, rdy;
      logic [12:0] sd;
      p   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 1) != 0);
      ld  = ($urandom_range(0, 63) == 0);
      sd  = ($urandom_range(0, 3) == 0) ? 13'h0 : 13'($urandom);
      applyStimulus(p, ld, sd, rdy, "random");
    end

    // Asynchronous reset in HOLD
    waitValid("pre-reset");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset valid", 32'(rndValid), 32'd0);
    checkOutput("async reset rnd", 32'(rnd), 32'd0);
    checkOutput("async reset rej", 32'(rejectCnt), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    modelReset();
    checkMain("after reset");

    // 4-bit instance: period 15, never zero, no rejections
    period = 1;
    e = 1;
    while (lfsrNext(e, 4, 'hC) != 1 && period < 100) begin
      e = lfsrNext(e, 4, 'hC);
      period++;
    end
    reset4 = 1'b0;
    e = 1;
    gap = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clock);
      #1;
      e = lfsrNext(e, 4, 'hC);
      checkOutput("w4 lfsr", 32'(dut4.u_core.lfsr_q), 32'(e));
      checkOutput("w4 nonzero", 32'(dut4.u_core.lfsr_q != 4'h0), 32'd1);
      if (gap == 0 && dut4.u_core.lfsr_q == 4'h1) gap = i;
    end
    checkOutput("w4 period", 32'(gap), 32'(period));
    checkOutput("w4 period is 15", 32'(gap), 32'd15);
    checkOutput("w4 no rejects", 32'(rej4), 32'd0);

    // RANGE=1 instance: only zero accepted, statistic saturates
    resetR = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock);
      #1;
      if (validR) checkOutput("range1 rnd", 32'(rndR), 32'd0);
    end
    checkOutput("range1 saturate", 32'(rejR), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
